// File: rtl/dec_entry_to_bin.sv
// Two-digit decimal entry converted to a 6-bit binary value.
// The operator sets a BCD digit on the switches and presses enter, once for the
// tens digit and once for the ones digit. A completed entry of 0..63 appears on
// binOut with binValid high. Invalid digits or values above 63 park the block in
// an error state until clear or reset.
//
// Optional build macro: DEC_ENTRY_DEBOUNCE_EN
//   When defined, the synchronized enter level must hold for DEBOUNCE_CYCLES
//   consecutive cycles before it is accepted. When undefined, the edge detector
//   works directly on the synchronized level and DEBOUNCE_CYCLES is unused.
//
// Ports:
//   clock     in   system clock, rising-edge
//   rstIn     in   synchronous active-high reset
//   digitIn   in   [3:0] BCD digit from switches
//   enterBtn  in   raw enter push button (asynchronous)
//   clearBtn  in   raw clear button (asynchronous, level-sensitive)
//   binOut    out  [5:0] entered value in binary
//   binValid  out  binOut holds a completed in-range entry
//   errFlag   out  block is in the error state
//   phase     out  [1:0] state: TENS=0, ONES=1, DONE=2, ERR=3
//   tensEcho  out  [3:0] captured tens digit
//   onesEcho  out  [3:0] captured ones digit
module dec_entry_to_bin #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       clock,
  input  logic       rstIn,
  input  logic [3:0] digitIn,
  input  logic       enterBtn,
  input  logic       clearBtn,
  output logic [5:0] binOut,
  output logic       binValid,
  output logic       errFlag,
  output logic [1:0] phase,
  output logic [3:0] tensEcho,
  output logic [3:0] onesEcho
);

  typedef enum logic [1:0] {
    ST_TENS = 2'd0,
    ST_ONES = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam int unsigned FLUSH_W = 2;

  state_t state;

  logic enter_s1, enter_s2;
  logic clear_s1, clear_s2;
  logic enter_lvl;
  logic enter_prev;
  logic enter_evt;
  logic rel_wait;
  logic [FLUSH_W-1:0] flush_cnt;
  logic digit_ok;
  logic [6:0] value;

  // Two-flop synchronizers for both raw buttons
  always_ff @(posedge clock) begin
    if (rstIn) begin
      enter_s1 <= 1'b0;
      enter_s2 <= 1'b0;
      clear_s1 <= 1'b0;
      clear_s2 <= 1'b0;
    end else begin
      enter_s1 <= enterBtn;
      enter_s2 <= enter_s1;
      clear_s1 <= clearBtn;
      clear_s2 <= clear_s1;
    end
  end

`ifdef DEC_ENTRY_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CNT_W-1:0] db_cnt;
  logic             db_lvl;

  // Accept a new level only after it has differed from the accepted level for
  // DEBOUNCE_CYCLES consecutive cycles; any return resets the count.
  always_ff @(posedge clock) begin
    if (rstIn) begin
      db_cnt <= '0;
      db_lvl <= 1'b0;
    end else if (enter_s2 == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt <= '0;
      db_lvl <= enter_s2;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

  assign enter_lvl = db_lvl;
`else
  assign enter_lvl = enter_s2;
`endif

  // After reset, wait for the synchronizer to flush and then for the button to
  // be seen released, so a press held through reset never creates an event.
  always_ff @(posedge clock) begin
    if (rstIn) begin
      enter_prev <= 1'b0;
      rel_wait   <= 1'b1;
      flush_cnt  <= '0;
    end else begin
      enter_prev <= enter_lvl;
      if (flush_cnt != FLUSH_W'(2)) begin
        flush_cnt <= flush_cnt + FLUSH_W'(1);
      end else if (!enter_s2) begin
        rel_wait <= 1'b0;
      end
    end
  end

  assign enter_evt = enter_lvl & ~enter_prev & ~rel_wait;
  assign digit_ok  = (digitIn <= 4'd9);
  // tens*10 + ones as shifts; max 99 fits in 7 bits
  assign value     = (7'(tensEcho) << 3) + (7'(tensEcho) << 1) + 7'(digitIn);

  // Entry state machine with registered outputs; clear overrides any enter event
  always_ff @(posedge clock) begin
    if (rstIn || clear_s2) begin
      state    <= ST_TENS;
      binOut   <= '0;
      binValid <= 1'b0;
      errFlag  <= 1'b0;
      tensEcho <= '0;
      onesEcho <= '0;
    end else if (enter_evt) begin
      case (state)
        ST_TENS, ST_DONE: begin
          binValid <= 1'b0;
          if (digit_ok) begin
            tensEcho <= digitIn;
            onesEcho <= '0;
            state    <= ST_ONES;
          end else begin
            errFlag <= 1'b1;
            state   <= ST_ERR;
          end
        end
        ST_ONES: begin
          if (!digit_ok) begin
            errFlag <= 1'b1;
            state   <= ST_ERR;
          end else begin
            onesEcho <= digitIn;
            if (value <= 7'd63) begin
              binOut   <= value[5:0];
              binValid <= 1'b1;
              state    <= ST_DONE;
            end else begin
              errFlag <= 1'b1;
              state   <= ST_ERR;
            end
          end
        end
        default: begin
          // Error state ignores enter; only clear or reset leaves it
          errFlag  <= 1'b1;
          binValid <= 1'b0;
          state    <= ST_ERR;
        end
      endcase
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_dec_entry_to_bin.sv
// Self-checking bench for dec_entry_to_bin with DEBOUNCE_CYCLES=4: directed
// scenarios followed by random digit entry against a behavioural model.
module tb_dec_entry_to_bin;

  localparam int unsigned DB = 4;
  localparam int HOLD = 10;
  localparam int GAP  = 10;

  logic       clock = 1'b0;
  logic       rstIn = 1'b1;
  logic [3:0] digitIn = 4'd0;
  logic       enterBtn = 1'b0;
  logic       clearBtn = 1'b0;
  logic [5:0] binOut;
  logic       binValid;
  logic       errFlag;
  logic [1:0] phase;
  logic [3:0] tensEcho;
  logic [3:0] onesEcho;

  dec_entry_to_bin #(.DEBOUNCE_CYCLES(DB)) dut (
    .clock    (clock),
    .rstIn    (rstIn),
    .digitIn  (digitIn),
    .enterBtn (enterBtn),
    .clearBtn (clearBtn),
    .binOut   (binOut),
    .binValid (binValid),
    .errFlag  (errFlag),
    .phase    (phase),
    .tensEcho (tensEcho),
    .onesEcho (onesEcho)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the entry: decimal value, digits and status
  int m_phase, m_tens, m_ones, m_bin, m_valid, m_err;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".phase"},    int'(phase),    m_phase);
    check_eq({tag, ".binOut"},   int'(binOut),   m_bin);
    check_eq({tag, ".binValid"}, int'(binValid), m_valid);
    check_eq({tag, ".errFlag"},  int'(errFlag),  m_err);
    check_eq({tag, ".tens"},     int'(tensEcho), m_tens);
    check_eq({tag, ".ones"},     int'(onesEcho), m_ones);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic void model_clear();
    m_phase = 0; m_tens = 0; m_ones = 0; m_bin = 0; m_valid = 0; m_err = 0;
  endfunction

  function automatic void model_error();
    m_phase = 3; m_err = 1; m_valid = 0;
  endfunction

  // One accepted enter with digit d, described in decimal terms
  function automatic void model_press(input int d);
    int v;
    case (m_phase)
      0, 2: begin
        m_valid = 0;
        if (d <= 9) begin m_tens = d; m_ones = 0; m_phase = 1; end
        else model_error();
      end
      1: begin
        if (d > 9) model_error();
        else begin
          m_ones = d;
          v = 10 * m_tens + d;
          if (v <= 63) begin m_bin = v; m_valid = 1; m_phase = 2; end
          else model_error();
        end
      end
      default: ;
    endcase
  endfunction

  task automatic press(input int d);
    digitIn = 4'(d);
    enterBtn = 1'b1;
    cycles(HOLD);
    enterBtn = 1'b0;
    cycles(GAP);
    model_press(d);
  endtask

  task automatic do_clear();
    clearBtn = 1'b1;
    cycles(5);
    clearBtn = 1'b0;
    cycles(4);
    model_clear();
  endtask

  initial begin
    model_clear();
    cycles(3);
    rstIn = 1'b0;
    cycles(1);
    check_all("reset");

    // 4 then 2
    press(4);
    check_all("tens4");
    press(2);
    check_all("val42");
    check_eq("val42.abs", int'(binOut), 42);

    // 63 in range, 64 out of range
    do_clear();
    press(6); press(3);
    check_all("val63");
    press(6); press(4);
    check_all("val64err");

    // Bad tens digit, presses ignored in ERR, then clear
    do_clear();
    check_all("clr1");
    press(11);
    check_all("tens11");
    press(3);
    check_all("err_hold");
    do_clear();
    check_all("clr2");

    // New entry after a valid value, then clear with simultaneous enter
    press(4); press(2); press(1);
    check_all("restart1");
    digitIn = 4'd5;
    enterBtn = 1'b1;
    clearBtn = 1'b1;
    cycles(12);
    clearBtn = 1'b0;
    cycles(6);
    enterBtn = 1'b0;
    cycles(GAP);
    model_clear();
    check_all("clr_enter");

`ifdef DEC_ENTRY_DEBOUNCE_EN
    // Short glitch is filtered
    press(7);
    digitIn = 4'd3;
    enterBtn = 1'b1;
    cycles(2);
    enterBtn = 1'b0;
    cycles(GAP);
    check_all("glitch");
    do_clear();
`endif

    // Reset in ONES with enter held through it
    press(4);
    check_all("pre_rst");
    digitIn = 4'd7;
    enterBtn = 1'b1;
    cycles(1);
    rstIn = 1'b1;
    cycles(1);
    rstIn = 1'b0;
    model_clear();
    cycles(HOLD + 4);
    check_all("rst_held");
    enterBtn = 1'b0;
    cycles(GAP);
    check_all("rst_release");
    press(5);
    check_all("rst_repress");

    // Random entry with occasional clears
    for (int i = 0; i < 80; i++) begin
      int d;
      if (($urandom % 8) == 0) begin
        do_clear();
        check_all("rnd_clr");
      end
      if (($urandom % 4) == 0) d = int'($urandom_range(0, 15));
      else d = int'($urandom_range(0, 9));
      press(d);
      check_all($sformatf("rnd%0d_d%0d", i, d));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
